// File: rtl/ps2_move_decoder_pkg.sv
// Shared constants and decoder state encoding for the PS/2 arrow-key path.
// Scan codes follow PS/2 set 2.
package ps2_move_decoder_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } dec_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronisers, clock glitch filter, bit counter,
// mid-frame timeout and odd-parity check.
module ps2_frame_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       err,
   output logic       drop
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    cs;
   logic [1:0]    ds;
   logic          filt;
   logic [FW-1:0] fcnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    sr;
   logic          par;
   logic [TW-1:0] tcnt;
   logic          fall;

   // Filter is about to drop low this cycle: that is the bit event.
   assign fall = filt && !cs[1] && (fcnt == FMAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         cs         <= 2'b11;
         ds         <= 2'b11;
         filt       <= 1'b1;
         fcnt       <= '0;
         bit_cnt    <= '0;
         sr         <= '0;
         par        <= 1'b0;
         tcnt       <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         err        <= 1'b0;
         drop       <= 1'b0;
      end else begin
         cs         <= {cs[0], ps2_clk};
         ds         <= {ds[0], ps2_data};
         byte_valid <= 1'b0;
         err        <= 1'b0;
         drop       <= 1'b0;

         if (cs[1] == filt) begin
            fcnt <= '0;
         end else if (fcnt == FMAX) begin
            filt <= cs[1];
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end

         if (fall) begin
            tcnt <= '0;
            if (bit_cnt == 4'd0) begin
               if (ds[1]) err <= 1'b1;
               else       bit_cnt <= 4'd1;
            end else if (bit_cnt <= 4'd8) begin
               sr      <= {ds[1], sr[7:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
               par     <= ds[1];
               bit_cnt <= 4'd10;
            end else begin
               bit_cnt <= 4'd0;
               if (ds[1] && (^{sr, par})) begin
                  rx_byte    <= sr;
                  byte_valid <= 1'b1;
               end else begin
                  err  <= 1'b1;
                  drop <= 1'b1;
               end
            end
         end else if (bit_cnt != 4'd0) begin
            if (tcnt == TMAX) begin
               err     <= 1'b1;
               drop    <= 1'b1;
               bit_cnt <= 4'd0;
               tcnt    <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end else begin
            tcnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard front end: decodes extended arrow make codes into
// single-cycle move pulses for the square-position logic.
module ps2_move_decoder
   import ps2_move_decoder_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic       move_up,
   output logic       move_down,
   output logic       move_left,
   output logic       move_right,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       err;
   logic       drop;
   dec_state_t state;
   dec_state_t state_nx;
   logic       up_nx;
   logic       down_nx;
   logic       left_nx;
   logic       right_nx;

   ps2_frame_rx #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk       (Clock),
      .rst       (Reset),
      .ps2_clk   (PS2_CLK),
      .ps2_data  (PS2_DATA),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .err       (err),
      .drop      (drop)
   );

   assign scan_code  = rx_byte;
   assign scan_valid = byte_valid;
   assign frame_err  = err;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         move_up    <= 1'b0;
         move_down  <= 1'b0;
         move_left  <= 1'b0;
         move_right <= 1'b0;
      end else begin
         state      <= state_nx;
         move_up    <= up_nx;
         move_down  <= down_nx;
         move_left  <= left_nx;
         move_right <= right_nx;
      end
   end

   always_comb begin
      state_nx = state;
      up_nx    = 1'b0;
      down_nx  = 1'b0;
      left_nx  = 1'b0;
      right_nx = 1'b0;
      if (drop) begin
         state_nx = IDLE;
      end else if (byte_valid) begin
         unique case (state)
            IDLE: begin
               if (rx_byte == PS2_EXT)      state_nx = EXT;
               else if (rx_byte == PS2_BRK) state_nx = BRK;
               else                         state_nx = IDLE;
            end
            EXT: begin
               state_nx = IDLE;
               case (rx_byte)
                  KEY_UP:    up_nx    = 1'b1;
                  KEY_DOWN:  down_nx  = 1'b1;
                  KEY_LEFT:  left_nx  = 1'b1;
                  KEY_RIGHT: right_nx = 1'b1;
                  PS2_BRK:   state_nx = EXT_BRK;
                  PS2_EXT:   state_nx = EXT;
                  default:   state_nx = IDLE;
               endcase
            end
            BRK:     state_nx = IDLE;
            EXT_BRK: state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Randomised scoreboard bench for ps2_move_decoder with a sequence-level
// reference model of the arrow-key decoding rules.
module tb_ps2_move_decoder;

   localparam int FLEN = 8;
   localparam int TOUT = 3000;
   localparam int H    = 12;
   localparam int GAP  = 30;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       PS2_CLK = 1'b1;
   logic       PS2_DATA = 1'b1;
   logic       move_up, move_down, move_left, move_right;
   logic [7:0] scan_code;
   logic       scan_valid, frame_err;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_sv = -10;
   int exp_err = 0;
   bit started = 1'b0;

   logic [7:0] scan_q[$];
   int         move_q[$];
   logic [7:0] pending[$];
   logic [7:0] arrows[4];

   ps2_move_decoder #(
      .FILTER_LEN    (FLEN),
      .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .PS2_CLK   (PS2_CLK),
      .PS2_DATA  (PS2_DATA),
      .move_up   (move_up),
      .move_down (move_down),
      .move_left (move_left),
      .move_right(move_right),
      .scan_code (scan_code),
      .scan_valid(scan_valid),
      .frame_err (frame_err)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
      end
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge Clock);
   endtask

   // Model: a key sequence is a run of E0/F0 prefixes and a final code.
   function automatic void model_code(input logic [7:0] b);
      bit has_brk = 1'b0;
      int dir = -1;
      foreach (pending[i]) if (pending[i] == 8'hF0) has_brk = 1'b1;
      for (int i = 0; i < 4; i++) if (arrows[i] == b) dir = i;
      if (has_brk) begin
         pending.delete();
      end else if (b == 8'hE0 || b == 8'hF0) begin
         pending.push_back(b);
      end else begin
         if (pending.size() > 0 && dir >= 0) move_q.push_back(dir);
         pending.delete();
      end
   endfunction

   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input bit glitch, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         PS2_DATA = f[i];
         wait_cyc(H);
         if (glitch && i == 3) begin
            PS2_CLK = 1'b0;
            wait_cyc(3);
            PS2_CLK = 1'b1;
            wait_cyc(H);
         end
         PS2_CLK = 1'b0;
         wait_cyc(H);
         if (glitch && i == 6) begin
            PS2_CLK = 1'b1;
            wait_cyc(FLEN - 3);
            PS2_CLK = 1'b0;
            wait_cyc(H);
         end
         PS2_CLK = 1'b1;
      end
      PS2_DATA = 1'b1;
      wait_cyc(GAP);
   endtask

   task automatic issue(input logic [7:0] b, input bit bad_par, input bit glitch);
      if (bad_par) begin
         exp_err++;
         pending.delete();
      end else begin
         scan_q.push_back(b);
         model_code(b);
      end
      send_frame(b, bad_par, glitch, 11);
   endtask

   task automatic check_idle_outputs(input string name);
      chk(name, {move_up, move_down, move_left, move_right,
                 scan_code, scan_valid, frame_err}, 32'd0);
   endtask

   always @(negedge Clock) begin
      if (started && !Reset) begin
         logic [3:0] mv;
         mv = {move_right, move_left, move_down, move_up};
         if (scan_valid) begin
            chk("scan_expected", scan_q.size() > 0, 1);
            if (scan_q.size() > 0) chk("scan_code", scan_code, scan_q.pop_front());
            last_sv = cyc;
         end
         if (mv != 4'd0) begin
            chk("move_onehot", $countones(mv), 1);
            chk("move_latency", cyc, last_sv + 1);
            chk("move_expected", move_q.size() > 0, 1);
            if (move_q.size() > 0) chk("move_dir", mv, 4'd1 << move_q.pop_front());
         end
         if (frame_err) begin
            chk("err_expected", exp_err > 0, 1);
            if (exp_err > 0) exp_err--;
         end
      end
   end

   initial begin
      repeat (90000) @(posedge Clock);
      $display("FAIL watchdog cycle budget expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [7:0] a;
      arrows[0] = 8'h75;
      arrows[1] = 8'h72;
      arrows[2] = 8'h6B;
      arrows[3] = 8'h74;

      wait_cyc(5);
      @(negedge Clock);
      check_idle_outputs("reset_outputs");
      @(posedge Clock);
      Reset = 1'b0;
      started = 1'b1;
      wait_cyc(20);

      issue(8'h1C, 0, 0);
      for (int i = 0; i < 4; i++) begin
         issue(8'hE0, 0, 0);
         issue(arrows[i], 0, 0);
      end
      issue(8'hE0, 0, 0);
      issue(8'hF0, 0, 0);
      issue(8'h75, 0, 0);
      issue(8'h75, 0, 0);
      issue(8'hE0, 0, 0);
      issue(8'h75, 0, 0);
      issue(8'hE0, 0, 0);
      issue(8'h75, 0, 0);

      issue(8'hE0, 0, 0);
      issue(8'h75, 1, 0);
      issue(8'h75, 0, 0);

      issue(8'hE0, 0, 0);
      exp_err++;
      pending.delete();
      send_frame(8'h55, 0, 0, 5);
      wait_cyc(TOUT + 200);
      issue(8'hE0, 0, 0);
      issue(8'h6B, 0, 0);

      issue(8'hE0, 0, 1);
      issue(8'h74, 0, 1);
      issue(8'h3A, 0, 1);

      issue(8'hE0, 0, 0);
      send_frame(8'h72, 0, 0, 4);
      Reset = 1'b1;
      pending.delete();
      wait_cyc(4);
      @(negedge Clock);
      check_idle_outputs("midframe_reset");
      @(posedge Clock);
      Reset = 1'b0;
      wait_cyc(20);
      issue(8'h72, 0, 0);
      issue(8'hE0, 0, 0);
      issue(8'h72, 0, 0);

      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 5);
         a = arrows[$urandom_range(0, 3)];
         unique case (r)
            0: begin
               issue(8'hE0, 0, $urandom_range(0, 3) == 0);
               issue(a, 0, $urandom_range(0, 3) == 0);
            end
            1: begin
               issue(8'hE0, 0, 0);
               issue(8'hF0, 0, 0);
               issue(a, 0, 0);
            end
            2: issue(a, 0, 0);
            3: issue(8'($urandom_range(0, 255)), 0, $urandom_range(0, 1) == 1);
            4: begin
               issue(8'hE0, 0, 0);
               issue(a, 1, 0);
               issue(a, 0, 0);
            end
            default: begin
               issue(8'hE0, 0, 0);
               issue(8'hE0, 0, 0);
               issue(a, 0, 0);
            end
         endcase
      end

      wait_cyc(100);
      chk("scan_q_drained", scan_q.size(), 0);
      chk("move_q_drained", move_q.size(), 0);
      chk("err_drained", exp_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
